// File: rtl/seq_bit_serializer_pkg.sv
// seq_pkg: shared definitions for the sequence-detector serial path.
//   ser_state_t       - serializer state encoding (IDLE, SHIFT, PARITY)
//   SEQ_SER_WIDTH_MAX - widest word the serializer is meant to carry
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  localparam int SEQ_SER_WIDTH_MAX = 32;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word handshake in, serial bit stream out.
//   din, din_valid        - word offered by the upstream source
//   din_ready             - serializer can take the offered word this edge
//   bit_out, bit_valid    - serial bit and its qualifier
//   busy                  - a word is in flight
// Modports: master = upstream/consumer side, slave = serializer side.
interface seq_bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, bit_out, bit_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, bit_out, bit_valid, busy
  );
endinterface

// File: rtl/seq_bit_serializer_parity.sv
// seq_ser_parity: even parity (XOR reduction) of a WIDTH-bit word.
//   din - word to reduce
//   par - XOR of all bits of din
// Present only in builds with SEQ_SER_PARITY_EN defined.
`ifdef SEQ_SER_PARITY_EN
module seq_ser_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  output logic             par
);
  assign par = ^din;
endmodule
`endif

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial source for the sequence detector.
// Takes a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per clock on bit_out (qualified by bit_valid); back-to-back words stream
// with no idle gap.
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - seq_bit_serializer_if slave: din/din_valid/din_ready in,
//          bit_out/bit_valid/busy out
// Parameters: WIDTH (2..32), MSB_FIRST (1: bit WIDTH-1 first, 0: bit 0 first)
// Build option: define SEQ_SER_PARITY_EN to append one even-parity bit
// after every word (the PARITY state then carries din_ready instead of the
// last data bit).
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  seq_bit_serializer_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             bit_out;
  logic             bit_valid;
  logic             last;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

`ifdef SEQ_SER_PARITY_EN
  logic word_par;
  logic par_bit;

  // Parity is taken from din and latched at accept, so later shifting of
  // shreg cannot disturb it.
  seq_ser_parity #(.WIDTH(WIDTH)) u_parity (
    .din (bus.din),
    .par (word_par)
  );

  assign last = (state == PARITY);
`else
  assign last = (state == SHIFT) && (cnt == '0);
`endif

  // Ready during the final stream bit lets the next word load on the same
  // edge the current one ends, giving gap-free streaming.
  assign bus.din_ready = rst && ((state == IDLE) || last);
  assign accept        = bus.din_valid && bus.din_ready;
  assign bus.busy      = (state != IDLE);
  assign bus.bit_out   = bit_out;
  assign bus.bit_valid = bit_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else if (accept) begin
      // Accept is only possible in IDLE or on the final bit, so a load
      // always wins over finishing the current word.
      shreg     <= bus.din;
      bit_out   <= first_bit(bus.din);
      bit_valid <= 1'b1;
      cnt       <= CNT_LOAD;
      state     <= SHIFT;
`ifdef SEQ_SER_PARITY_EN
      par_bit   <= word_par;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != '0) begin
            shreg   <= shift_word(shreg);
            bit_out <= first_bit(shift_word(shreg));
            cnt     <= cnt - 1'b1;
          end else begin
`ifdef SEQ_SER_PARITY_EN
            state     <= PARITY;
            bit_out   <= par_bit;
            bit_valid <= 1'b1;
`else
            state     <= IDLE;
            bit_valid <= 1'b0;
`endif
          end
        end
`ifdef SEQ_SER_PARITY_EN
        PARITY: begin
          state     <= IDLE;
          bit_valid <= 1'b0;
        end
`endif
        // IDLE without accept: bit_out keeps its last value.
        default: begin
          state     <= IDLE;
          bit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Testbench for seq_bit_serializer: WIDTH=5 MSB-first and WIDTH=8 LSB-first
// instances (plus a WIDTH=4 instance when SEQ_SER_PARITY_EN is defined).
module tb_seq_bit_serializer;

`ifdef SEQ_SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int WC5 = 5 + PB;
  localparam int WC8 = 8 + PB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   exp5_q[$];
  bit   exp8_q[$];

  seq_bit_serializer_if #(.WIDTH(5)) b5();
  seq_bit_serializer_if #(.WIDTH(8)) b8();

  seq_bit_serializer #(.WIDTH(5), .MSB_FIRST(1)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b5)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

`ifdef SEQ_SER_PARITY_EN
  seq_bit_serializer_if #(.WIDTH(4)) b4();
  seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );
`endif

  always #5 clk = ~clk;

  // Reference model: expected serial bits for one word.
  function automatic void push5(input logic [4:0] w);
    for (int i = 4; i >= 0; i--) exp5_q.push_back(w[i]);
    if (PB != 0) exp5_q.push_back(^w);
  endfunction

  function automatic void push8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) exp8_q.push_back(w[i]);
    if (PB != 0) exp8_q.push_back(^w);
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    b5.din_valid = 1'b1;
    #1;
    total++; if (b5.bit_out !== 1'b0) begin bad++; $display("FAIL rst_bit_out got=%0b want=0", b5.bit_out); end
    total++; if (b5.bit_valid !== 1'b0) begin bad++; $display("FAIL rst_bit_valid got=%0b want=0", b5.bit_valid); end
    total++; if (b5.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", b5.busy); end
    total++; if (b5.din_ready !== 1'b0) begin bad++; $display("FAIL rst_din_ready got=%0b want=0", b5.din_ready); end
    total++; if (b8.bit_valid !== 1'b0) begin bad++; $display("FAIL rst_bit_valid8 got=%0b want=0", b8.bit_valid); end
    @(negedge clk);
    rst = 1'b1;
    b5.din_valid = 1'b0;
  endtask

  task automatic test_single();
    bit e;
    @(negedge clk);
    b5.din = 5'b11011;
    b5.din_valid = 1'b1;
    push5(5'b11011);
    total++; if (b5.din_ready !== 1'b1) begin bad++; $display("FAIL single_ready_c0 got=%0b want=1", b5.din_ready); end
    for (int c = 1; c <= WC5 + 1; c++) begin
      @(negedge clk);
      b5.din_valid = 1'b0;
      total++; if (b5.din_ready !== (c >= WC5)) begin bad++; $display("FAIL single_ready c=%0d got=%0b want=%0b", c, b5.din_ready, (c >= WC5)); end
      if (c <= WC5) begin
        e = exp5_q.pop_front();
        total++; if (b5.bit_valid !== 1'b1 || b5.bit_out !== e) begin bad++; $display("FAIL single_bit c=%0d got v=%0b b=%0b want v=1 b=%0b", c, b5.bit_valid, b5.bit_out, e); end
        total++; if (b5.busy !== 1'b1) begin bad++; $display("FAIL single_busy c=%0d got=%0b want=1", c, b5.busy); end
      end else begin
        total++; if (b5.bit_valid !== 1'b0 || b5.busy !== 1'b0) begin bad++; $display("FAIL single_end got v=%0b busy=%0b want v=0 busy=0", b5.bit_valid, b5.busy); end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    @(negedge clk);
    b5.din = 5'b11011;
    b5.din_valid = 1'b1;
    push5(5'b11011);
    push5(5'b01101);
    for (int c = 0; c <= 2 * WC5 + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c == WC5) b5.din = 5'b01101;
      if (c == WC5 + 1) b5.din_valid = 1'b0;
      if (c < 2 * WC5) begin
        total++; if (b5.din_ready !== (c == 0 || c == WC5)) begin bad++; $display("FAIL b2b_ready c=%0d got=%0b want=%0b", c, b5.din_ready, (c == 0 || c == WC5)); end
      end
      if (c >= 1 && c <= 2 * WC5) begin
        e = exp5_q.pop_front();
        total++; if (b5.bit_valid !== 1'b1 || b5.bit_out !== e) begin bad++; $display("FAIL b2b_bit c=%0d got v=%0b b=%0b want v=1 b=%0b", c, b5.bit_valid, b5.bit_out, e); end
      end
      if (c == 2 * WC5 + 1) begin
        total++; if (b5.bit_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got v=%0b want v=0", b5.bit_valid); end
      end
    end
  endtask

  task automatic test_lsb_first();
    bit e;
    @(negedge clk);
    b8.din = 8'hA5;
    b8.din_valid = 1'b1;
    push8(8'hA5);
    for (int c = 1; c <= WC8 + 1; c++) begin
      @(negedge clk);
      b8.din_valid = 1'b0;
      if (c <= WC8) begin
        e = exp8_q.pop_front();
        total++; if (b8.bit_valid !== 1'b1 || b8.bit_out !== e) begin bad++; $display("FAIL lsb_bit c=%0d got v=%0b b=%0b want v=1 b=%0b", c, b8.bit_valid, b8.bit_out, e); end
      end else begin
        total++; if (b8.bit_valid !== 1'b0) begin bad++; $display("FAIL lsb_end got v=%0b want v=0", b8.bit_valid); end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    bit e;
    @(negedge clk);
    b8.din = 8'hE7;
    b8.din_valid = 1'b1;
    push8(8'hE7);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      b8.din_valid = 1'b0;
      e = exp8_q.pop_front();
      total++; if (b8.bit_valid !== 1'b1 || b8.bit_out !== e) begin bad++; $display("FAIL midrst_pre c=%0d got v=%0b b=%0b want v=1 b=%0b", c, b8.bit_valid, b8.bit_out, e); end
    end
    @(negedge clk);
    rst = 1'b0;
    exp8_q.delete();
    #1;
    total++; if (b8.bit_valid !== 1'b0 || b8.bit_out !== 1'b0 || b8.busy !== 1'b0) begin bad++; $display("FAIL midrst_out got v=%0b b=%0b busy=%0b want 0 0 0", b8.bit_valid, b8.bit_out, b8.busy); end
    total++; if (b8.din_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%0b want=0", b8.din_ready); end
    @(negedge clk);
    rst = 1'b1;
    b8.din = 8'hFF;
    b8.din_valid = 1'b1;
    push8(8'hFF);
    #1;
    total++; if (b8.din_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got=%0b want=1", b8.din_ready); end
    for (int c = 1; c <= WC8 + 1; c++) begin
      @(negedge clk);
      b8.din_valid = 1'b0;
      if (c <= WC8) begin
        e = exp8_q.pop_front();
        total++; if (b8.bit_valid !== 1'b1 || b8.bit_out !== e) begin bad++; $display("FAIL midrst_ff c=%0d got v=%0b b=%0b want v=1 b=%0b", c, b8.bit_valid, b8.bit_out, e); end
      end else begin
        total++; if (b8.bit_valid !== 1'b0) begin bad++; $display("FAIL midrst_end got v=%0b want v=0", b8.bit_valid); end
      end
    end
  endtask

  task automatic test_busy_pulse();
    bit e;
    @(negedge clk);
    b5.din = 5'b10010;
    b5.din_valid = 1'b1;
    push5(5'b10010);
    for (int c = 1; c <= WC5 + 1; c++) begin
      @(negedge clk);
      b5.din = 5'($urandom);
      b5.din_valid = (c == 2 || c == 3);
      if (c == 2 || c == 3) begin
        total++; if (b5.din_ready !== 1'b0) begin bad++; $display("FAIL pulse_ready c=%0d got=%0b want=0", c, b5.din_ready); end
      end
      if (c <= WC5) begin
        e = exp5_q.pop_front();
        total++; if (b5.bit_valid !== 1'b1 || b5.bit_out !== e) begin bad++; $display("FAIL pulse_bit c=%0d got v=%0b b=%0b want v=1 b=%0b", c, b5.bit_valid, b5.bit_out, e); end
      end else begin
        total++; if (b5.bit_valid !== 1'b0 || b5.busy !== 1'b0) begin bad++; $display("FAIL pulse_end got v=%0b busy=%0b want 0 0", b5.bit_valid, b5.busy); end
      end
    end
  endtask

`ifdef SEQ_SER_PARITY_EN
  task automatic test_parity();
    bit e;
    bit exp4_q[$];
    exp4_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    b4.din = 4'b1011;
    b4.din_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      b4.din_valid = 1'b0;
      if (c <= 5) begin
        e = exp4_q.pop_front();
        total++; if (b4.bit_valid !== 1'b1 || b4.bit_out !== e) begin bad++; $display("FAIL par_bit c=%0d got v=%0b b=%0b want v=1 b=%0b", c, b4.bit_valid, b4.bit_out, e); end
        total++; if (b4.din_ready !== (c == 5)) begin bad++; $display("FAIL par_ready c=%0d got=%0b want=%0b", c, b4.din_ready, (c == 5)); end
      end else begin
        total++; if (b4.bit_valid !== 1'b0) begin bad++; $display("FAIL par_end got v=%0b want v=0", b4.bit_valid); end
      end
    end
  endtask
`endif

  initial begin
    b5.din = '0;
    b5.din_valid = 1'b0;
    b8.din = '0;
    b8.din_valid = 1'b0;
`ifdef SEQ_SER_PARITY_EN
    b4.din = '0;
    b4.din_valid = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_busy_pulse();
`ifdef SEQ_SER_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_bit_serializer.md
# seq_bit_serializer

Parallel-to-serial source for the sequence-detector path. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `bit_out`, qualified by `bit_valid`. `bit_out` drives the detector's serial `in` input directly. Back-to-back words stream with no idle gap.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `din` input WIDTH: word to serialize.
- `din_valid` input 1: `din` holds a word.
- `din_ready` output 1: the block will accept `din` at this edge.
- `bit_out` output 1: current serial bit.
- `bit_valid` output 1: `bit_out` is a live stream bit.
- `busy` output 1: a word is in flight (the state is not IDLE).

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro enabled).
- Registers:
  - `shreg[WIDTH-1:0]`
  - `cnt[$clog2(WIDTH+1)-1:0]`
  - `state`
  - `bit_out`
  - `bit_valid`
- Reset (`rst` low, takes effect immediately): state=IDLE, shreg=0, cnt=0, bit_out=0, bit_valid=0, busy=0, din_ready=0.
- `din_ready` is combinational and is 1 when `rst` is high and either:
  - state=IDLE, or
  - the current cycle is the final stream bit (last data bit, or the PARITY cycle when enabled).
- Accept means `din_valid && din_ready` at a rising edge.
- IDLE:
  - On accept: load shreg=`din`, put the first bit on `bit_out`, set bit_valid=1, cnt=WIDTH-1, go to SHIFT.
  - Otherwise: bit_valid=0 and bit_out holds its value.
- SHIFT:
  - Each edge with cnt!=0: shift shreg (left if MSB_FIRST, else right), present the next bit, decrement cnt.
  - At the cnt==0 edge, without parity:
    - accept → reload and continue in SHIFT;
    - no accept → go to IDLE with bit_valid=0.
  - At the cnt==0 edge, with parity: go to PARITY.
- PARITY: bit_out = even parity (XOR) of the accepted word, bit_valid=1. Next edge:
  - accept → reload into SHIFT;
  - no accept → IDLE.
- Parity is computed from the word captured at accept time. It is not computed from shreg.
- `din` is sampled only on accept. Changes to `din` at other times have no effect.
- Words offered with `din_valid` while `din_ready`=0 are not lost: the upstream holds them, per the handshake.

## Timing
- Latency: the first bit appears on `bit_out` in the cycle after the accept edge. All outputs are registered except `din_ready` and `busy`.
- A word occupies exactly WIDTH cycles of `bit_valid`, or WIDTH+1 with parity.
- Continuous streaming: if `din_valid` is held high, `bit_valid` stays 1 with no gap between words.
- Reset asserted mid-word: the partial word is discarded and the outputs return to reset values immediately.
- Reset release: the first accept is possible at the first rising edge after `rst` goes high.
- Simultaneous last-bit and accept: the reload takes priority and the state stays SHIFT. There is no transit through IDLE.

## Configuration
- `SEQ_SER_PARITY_EN` defined:
  - the PARITY state exists;
  - one even-parity bit is appended after each word;
  - `din_ready` is asserted during the PARITY cycle instead of the last data bit.
- Not defined:
  - the PARITY state and parity logic are absent;
  - words are exactly WIDTH bits.

## Structure
- Shared package `seq_pkg`:
  - the state encoding typedef `ser_state_t` (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2);
  - the constant `SEQ_SER_WIDTH_MAX=32`.
- One sub-module, `seq_ser_parity`: a combinational XOR reduction of WIDTH bits. It is instantiated only under `SEQ_SER_PARITY_EN`.

## Test plan
- WIDTH=5, MSB_FIRST=1, accept `din`=5'b11011 at edge 0 → `bit_out`=1,1,0,1,1 on cycles 1–5, `bit_valid`=1 on cycles 1–5, 0 on cycle 6; the downstream detector pulses once.
- WIDTH=5, `din_valid` held high with words 5'b11011 then 5'b01101 → 10 consecutive valid bits 1,1,0,1,1,0,1,1,0,1; `din_ready` high on cycles 0 and 5 only.
- MSB_FIRST=0, WIDTH=8, `din`=8'hA5 → bit sequence 1,0,1,0,0,1,0,1.
- `rst` driven low in cycle 3 of a WIDTH=8 word → `bit_valid`=0, `bit_out`=0 and `busy`=0 immediately; after release, a new word 8'hFF streams eight 1s from the cycle after accept.
- `SEQ_SER_PARITY_EN`, WIDTH=4, `din`=4'b1011 → bits 1,0,1,1 then parity 1; `din_ready` high only in the parity cycle.
- `din_valid` pulsed while busy with `din_ready`=0 → no reload occurs; the in-flight word completes unchanged.
